// File: rtl/latch_wr_if.sv
// Request/latch-bus bundle between the register-file write ports and the latch write controller.
interface latch_wr_if #(
  parameter int unsigned N_REGS = 8,
  parameter int unsigned AW     = 3,
  parameter int unsigned DW     = 8
);
  logic              req0_valid;
  logic [AW-1:0]     req0_addr;
  logic [DW-1:0]     req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [AW-1:0]     req1_addr;
  logic [DW-1:0]     req1_data;
  logic              req1_ready;
  logic [DW-1:0]     latch_d;
  logic [N_REGS-1:0] latch_en;
  logic              busy;
  logic              err;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  latch_d, latch_en, busy, err
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output latch_d, latch_en, busy, err
  );
endinterface

// File: rtl/latch_wr_ctrl.sv
// Round-robin write controller for a bank of active-low-enable gated D latches:
// each granted write is sequenced as a glitch-free setup -> open -> hold enable pulse.
module latch_wr_ctrl #(
  parameter int unsigned N_REGS   = 8,
  parameter int unsigned AW       = 3,
  parameter int unsigned DW       = 8,
  parameter int unsigned OPEN_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  latch_wr_if.slave  bus
);
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, SETUP, OPEN, HOLD} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     data_q, data_d;
  logic              last_q, last_d;
  logic [N_REGS-1:0] en_q, en_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              gnt0_c, gnt1_c;
  logic              in_range_c;

  // Next state, arbitration and next values of the registered latch-side outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    last_d  = last_q;
    gnt0_c  = 1'b0;
    gnt1_c  = 1'b0;
    en_d    = '1;

    case (state_q)
      IDLE: begin
        // last_q == 1 means requester 1 was granted last, so requester 0 wins a tie.
        if (!rst) begin
          gnt0_c = bus.req0_valid && (!bus.req1_valid || last_q);
          gnt1_c = bus.req1_valid && (!bus.req0_valid || !last_q);
        end
        if (gnt0_c) begin
          addr_d  = bus.req0_addr;
          data_d  = bus.req0_data;
          last_d  = 1'b0;
          state_d = SETUP;
        end else if (gnt1_c) begin
          addr_d  = bus.req1_addr;
          data_d  = bus.req1_data;
          last_d  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        state_d = OPEN;
        cnt_d   = CW'(OPEN_CYC - 1);
      end
      OPEN: begin
        if (cnt_q == '0) state_d = HOLD;
        else             cnt_d   = cnt_q - CW'(1);
      end
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    in_range_c = 32'(addr_d) < N_REGS;
    if (state_d == OPEN && in_range_c) begin
      for (int unsigned i = 0; i < N_REGS; i++) begin
        if (32'(addr_d) == i) en_d[i] = 1'b0;
      end
    end
    err_d  = (state_d == SETUP) && !in_range_c;
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset forces every enable closed at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b1;
      en_q    <= '1;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      last_q  <= last_d;
      en_q    <= en_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.req0_ready = gnt0_c;
  assign bus.req1_ready = gnt1_c;
  assign bus.latch_d    = data_q;
  assign bus.latch_en   = en_q;
  assign bus.err        = err_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_latch_wr_ctrl.sv
// Scoreboard bench for latch_wr_ctrl: stimulus queues expected grants, a monitor
// checks each transaction's enable/data sequence, and an invariant watcher runs throughout.
module tb_latch_wr_ctrl;
  localparam int unsigned N_REGS = 6;
  localparam int unsigned AW     = 3;
  localparam int unsigned DW     = 8;
  localparam int unsigned OC     = 2;
  localparam logic [N_REGS-1:0] ALL1 = {N_REGS{1'b1}};

  logic clk = 1'b0;
  logic rst;

  latch_wr_if #(.N_REGS(N_REGS), .AW(AW), .DW(DW)) bus ();

  latch_wr_ctrl #(.N_REGS(N_REGS), .AW(AW), .DW(DW), .OPEN_CYC(OC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int            who;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   grants = 0;
  int   last_acc = -100;
  bit   sb_on = 1'b1;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [N_REGS-1:0] en_pat(input logic [AW-1:0] a);
    logic [N_REGS-1:0] en;
    en = ALL1;
    for (int unsigned i = 0; i < N_REGS; i++) begin
      if (32'(a) == i) en[i] = 1'b0;
    end
    return en;
  endfunction

  // Follow one accepted transaction from its accept cycle to the IDLE cycle after HOLD.
  task automatic handle(input bit chained);
    exp_t e;
    int   who;
    who = bus.req1_ready ? 1 : 0;
    grants++;
    if (!sb_on) begin
      for (int k = 1; k <= int'(OC) + 3; k++) begin
        @(negedge clk);
        if (rst) return;
      end
      return;
    end
    if (chained) check("accept_spacing", 32'(cyc - last_acc), OC + 3);
    last_acc = cyc;
    check("one_ready", 32'(bus.req0_ready & bus.req1_ready), 0);
    check("unexpected_grant", 32'(sb.size() > 0), 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check("grant_who", 32'(who), 32'(e.who));
    for (int k = 1; k <= int'(OC) + 3; k++) begin
      @(negedge clk);
      if (rst) return;
      if (k <= int'(OC) + 2) begin
        check("busy", 32'(bus.busy), 1);
        check("latch_d", 32'(bus.latch_d), 32'(e.data));
        check("err", 32'(bus.err), 32'(k == 1 && 32'(e.addr) >= N_REGS));
        check("latch_en", 32'(bus.latch_en),
              (k >= 2 && k <= int'(OC) + 1) ? 32'(en_pat(e.addr)) : 32'(ALL1));
      end else begin
        check("busy_idle", 32'(bus.busy), 0);
        check("latch_d_idle", 32'(bus.latch_d), 32'(e.data));
      end
    end
  endtask

  // Monitor: a transaction ending on an IDLE cycle with a ready present is a back-to-back grant.
  initial begin
    bit chained;
    forever begin
      @(negedge clk);
      chained = 1'b0;
      while (!rst && (bus.req0_ready || bus.req1_ready)) begin
        handle(chained);
        chained = 1'b1;
      end
    end
  end

  // Invariants on every cycle outside reset.
  initial begin
    logic [DW-1:0]     prev_d;
    logic [N_REGS-1:0] prev_en;
    prev_d  = '0;
    prev_en = ALL1;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("onehot_en", 32'($countones(~bus.latch_en) <= 1), 1);
        check("ready_while_busy", 32'((bus.req0_ready | bus.req1_ready) & bus.busy), 0);
        if (bus.latch_d != prev_d) begin
          check("en_at_d_change", 32'(bus.latch_en), 32'(ALL1));
          check("en_before_d_change", 32'(prev_en), 32'(ALL1));
        end
      end
      prev_d  = bus.latch_d;
      prev_en = bus.latch_en;
    end
  end

  task automatic issue(input int who, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    bit   seen;
    e.who = who; e.addr = a; e.data = d;
    sb.push_back(e);
    seen = 1'b0;
    if (who == 0) begin
      bus.req0_valid = 1'b1; bus.req0_addr = a; bus.req0_data = d;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_addr = a; bus.req1_data = d;
    end
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = (who == 0) ? bus.req0_ready : bus.req1_ready;
    end
    check("issue_accepted", 32'(seen), 1);
    @(posedge clk);
    #1;
    if (who == 0) bus.req0_valid = 1'b0;
    else          bus.req1_valid = 1'b0;
  endtask

  task automatic push_exp(input int who, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    e.who = who; e.addr = a; e.data = d;
    sb.push_back(e);
  endtask

  task automatic wait_grants(input int n);
    for (int i = 0; i < 200 && grants < n; i++) @(negedge clk);
    check("grant_count", 32'(grants >= n), 1);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = (sb.size() == 0) && !bus.busy;
    end
    check("drain", 32'(done), 1);
  endtask

  initial begin
    int base;
    rst = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
    repeat (2) @(posedge clk);
    #1;
    bus.req0_valid = 1'b1;
    #1;
    check("rst_ready0", 32'(bus.req0_ready), 0);
    check("rst_latch_en", 32'(bus.latch_en), 32'(ALL1));
    check("rst_latch_d", 32'(bus.latch_d), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_err", 32'(bus.err), 0);
    bus.req0_valid = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;

    // single in-range write, then an out-of-range write from requester 1
    issue(0, 3'd3, 8'hA5);
    issue(1, 3'd7, 8'h3C);
    drain();

    // both held valid: pointer says req1 was last, so req0, req1, req0, req1
    @(posedge clk); #1;
    base = grants;
    push_exp(0, 3'd1, 8'h11); push_exp(1, 3'd2, 8'h22);
    push_exp(0, 3'd1, 8'h11); push_exp(1, 3'd2, 8'h22);
    bus.req0_valid = 1'b1; bus.req0_addr = 3'd1; bus.req0_data = 8'h11;
    bus.req1_valid = 1'b1; bus.req1_addr = 3'd2; bus.req1_data = 8'h22;
    wait_grants(base + 4);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    drain();

    // back-to-back words from requester 0
    @(posedge clk); #1;
    issue(0, 3'd0, 8'h01);
    issue(0, 3'd5, 8'h02);
    issue(0, 3'd4, 8'h03);
    drain();

    // abort a req0 write mid-pulse; without reset the tie would go to req1
    @(posedge clk); #1;
    issue(0, 3'd2, 8'h77);
    @(posedge clk);
    #3;
    check("pre_rst_en_low", 32'(bus.latch_en), 32'(en_pat(3'd2)));
    rst = 1'b1;
    #1;
    check("arst_latch_en", 32'(bus.latch_en), 32'(ALL1));
    check("arst_latch_d", 32'(bus.latch_d), 0);
    check("arst_busy", 32'(bus.busy), 0);
    base = grants;
    push_exp(0, 3'd1, 8'h44); push_exp(1, 3'd5, 8'h55);
    bus.req0_valid = 1'b1; bus.req0_addr = 3'd1; bus.req0_data = 8'h44;
    bus.req1_valid = 1'b1; bus.req1_addr = 3'd5; bus.req1_data = 8'h55;
    #1;
    check("arst_ready", 32'(bus.req0_ready | bus.req1_ready), 0);
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    wait_grants(base + 2);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    drain();

    // random traffic: only the invariant watcher judges this phase
    sb_on = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(posedge clk); #1;
      bus.req0_valid = 1'($urandom_range(0, 1));
      bus.req0_addr  = AW'($urandom_range(0, 7));
      bus.req0_data  = DW'($urandom_range(0, 255));
      bus.req1_valid = 1'($urandom_range(0, 1));
      bus.req1_addr  = AW'($urandom_range(0, 7));
      bus.req1_data  = DW'($urandom_range(0, 255));
    end
    @(posedge clk); #1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    drain();
    repeat (2) @(posedge clk);
    sb_on = 1'b1;

    check("sb_empty", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
